// File: rtl/branch_tracker_pkg.sv
// Shared sizing, state encoding and entry layout for the branch tracker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_tracker_pkg;

  localparam int BR_DEPTH = 4;
  localparam int BR_TAG_W = 2;
  localparam int BR_CNT_W = 3;
  localparam int PC_W     = 16;

  typedef enum logic {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } br_state_e;

  typedef logic [BR_TAG_W-1:0] br_tag_t;

  typedef struct packed {
    logic            valid;
    logic            resolved;
    logic [PC_W-1:0] alt_pc;
  } br_entry_t;

  // Age of a tag relative to the oldest in-flight branch (head); 0 = oldest.
  // Relies on the 2-bit tag wrapping naturally modulo the depth.
  function automatic br_tag_t tag_age(input br_tag_t tag, input br_tag_t head);
    return br_tag_t'(tag - head);
  endfunction

endpackage

// File: rtl/branch_entry_file.sv
// Storage for the in-flight branch entries: {valid, resolved, alt_pc} per tag.
// Latency: writes/clears take effect at the next edge; read port is combinational.
// Backpressure: none; the tracker guarantees one write per tag per cycle.
// Ports:
//   wr_en_i/wr_tag_i/wr_pc_i  allocate an entry (valid=1, resolved=0)
//   res_en_i/res_tag_i        mark an entry resolved
//   free_en_i/free_tag_i      retire the head entry
//   clr_mask_i                squash a set of entries on mispredict
//   rd_tag_i/rd_pc_o          recovery-PC read port
//   valid_o/resolved_o        per-entry status flags
module branch_entry_file
  import branch_tracker_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en_i,
  input  br_tag_t             wr_tag_i,
  input  logic [PC_W-1:0]     wr_pc_i,
  input  logic                res_en_i,
  input  br_tag_t             res_tag_i,
  input  logic                free_en_i,
  input  br_tag_t             free_tag_i,
  input  logic [BR_DEPTH-1:0] clr_mask_i,
  input  br_tag_t             rd_tag_i,
  output logic [PC_W-1:0]     rd_pc_o,
  output logic [BR_DEPTH-1:0] valid_o,
  output logic [BR_DEPTH-1:0] resolved_o
);

  br_entry_t ent_q [BR_DEPTH];
  br_entry_t ent_d [BR_DEPTH];

  // Clears win over writes: a squashed or retired slot never sees a
  // same-cycle write because the tracker blocks allocation on mispredict
  // and tail never equals a valid head.
  always_comb begin
    for (int i = 0; i < BR_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (clr_mask_i[i] || (free_en_i && free_tag_i == br_tag_t'(i))) begin
        ent_d[i].valid    = 1'b0;
        ent_d[i].resolved = 1'b0;
      end else if (wr_en_i && wr_tag_i == br_tag_t'(i)) begin
        ent_d[i].valid    = 1'b1;
        ent_d[i].resolved = 1'b0;
        ent_d[i].alt_pc   = wr_pc_i;
      end else if (res_en_i && res_tag_i == br_tag_t'(i)) begin
        ent_d[i].resolved = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BR_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BR_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < BR_DEPTH; i++) begin
      valid_o[i]    = ent_q[i].valid;
      resolved_o[i] = ent_q[i].resolved;
    end
    rd_pc_o = ent_q[rd_tag_i].alt_pc;
  end

endmodule

// File: rtl/branch_tracker.sv
// Tracks up to 4 in-flight conditional branches; retires in order, flushes younger on mispredict.
// Latency: alloc_ack combinational; state, has_mispredict/pc_recovery/flush_mask one edge after resolve.
// Backpressure: alloc refused (alloc_ack=0, dropped) when full, in RECOVER, or on a same-cycle mispredict.
// Ports:
//   alloc_vld/alloc_pc_alt -> alloc_tag/alloc_ack     decode-side allocation
//   resolve_vld/resolve_tag/resolve_mispred            execute-side resolution
//   brch_full, brch_cnt                                occupancy
//   has_mispredict, pc_recovery, flush_mask            one-cycle recovery pulse
module branch_tracker
  import branch_tracker_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_vld,
  input  logic [PC_W-1:0]     alloc_pc_alt,
  output logic [BR_TAG_W-1:0] alloc_tag,
  output logic                alloc_ack,
  input  logic                resolve_vld,
  input  logic [BR_TAG_W-1:0] resolve_tag,
  input  logic                resolve_mispred,
  output logic                brch_full,
  output logic                has_mispredict,
  output logic [PC_W-1:0]     pc_recovery,
  output logic [BR_DEPTH-1:0] flush_mask,
  output logic [BR_CNT_W-1:0] brch_cnt
);

  br_tag_t             head_q, head_d;
  br_tag_t             tail_q, tail_d;
  logic [BR_CNT_W-1:0] cnt_q, cnt_d;

  br_state_e           state_q;
  logic                mispredict_q;
  logic [PC_W-1:0]     pc_rec_q;
  logic [BR_DEPTH-1:0] flush_q;

  logic [BR_DEPTH-1:0] ent_vld;
  logic [BR_DEPTH-1:0] ent_res;
  logic [PC_W-1:0]     rd_pc;

  logic                res_hit;
  logic                mispred;
  logic                set_res;
  logic                free_en;
  br_tag_t             mis_age;
  logic [BR_DEPTH-1:0] flush_d;

  // Resolves against empty slots (never allocated or already squashed) are ignored.
  assign res_hit = resolve_vld & ent_vld[resolve_tag];
  assign mispred = res_hit & resolve_mispred;
  assign set_res = res_hit & ~resolve_mispred;

  // Retire the head when resolved, unless the head itself is being squashed.
  assign free_en = ent_vld[head_q] & ent_res[head_q] & ~(mispred & (resolve_tag == head_q));

  assign mis_age = tag_age(resolve_tag, head_q);

  // Squash the mispredicted branch and every valid branch younger than it.
  // Comparing ages (not raw tags) handles wrap and the full-buffer case.
  always_comb begin
    for (int i = 0; i < BR_DEPTH; i++) begin
      flush_d[i] = ent_vld[i] & (tag_age(br_tag_t'(i), head_q) >= mis_age);
    end
  end

  assign brch_full = (cnt_q == BR_CNT_W'(BR_DEPTH));
  assign brch_cnt  = cnt_q;
  assign alloc_tag = tail_q;
  assign alloc_ack = alloc_vld & ~brch_full & (state_q == NORMAL) & ~mispred;

  always_comb begin
    head_d = head_q + br_tag_t'(free_en);
    if (mispred) begin
      tail_d = resolve_tag;
      // Survivors are exactly the entries older than the mispredicted one.
      cnt_d  = BR_CNT_W'(mis_age) - BR_CNT_W'(free_en);
    end else begin
      tail_d = tail_q + br_tag_t'(alloc_ack);
      cnt_d  = cnt_q + BR_CNT_W'(alloc_ack) - BR_CNT_W'(free_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Recovery FSM: RECOVER lasts exactly the has_mispredict cycle so that
  // wrong-path branches still sitting in decode are refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= NORMAL;
      mispredict_q <= 1'b0;
      pc_rec_q     <= '0;
      flush_q      <= '0;
    end else if (mispred) begin
      state_q      <= RECOVER;
      mispredict_q <= 1'b1;
      pc_rec_q     <= rd_pc;
      flush_q      <= flush_d;
    end else begin
      state_q      <= NORMAL;
      mispredict_q <= 1'b0;
      pc_rec_q     <= '0;
      flush_q      <= '0;
    end
  end

  assign has_mispredict = mispredict_q;
  assign pc_recovery    = pc_rec_q;
  assign flush_mask     = flush_q;

  branch_entry_file u_entries (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (alloc_ack),
    .wr_tag_i   (tail_q),
    .wr_pc_i    (alloc_pc_alt),
    .res_en_i   (set_res),
    .res_tag_i  (resolve_tag),
    .free_en_i  (free_en),
    .free_tag_i (head_q),
    .clr_mask_i (mispred ? flush_d : '0),
    .rd_tag_i   (resolve_tag),
    .rd_pc_o    (rd_pc),
    .valid_o    (ent_vld),
    .resolved_o (ent_res)
  );

endmodule

// File: tb/tb_branch_tracker.sv
// Self-checking bench for branch_tracker: directed scenarios plus random traffic vs a queue model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_branch_tracker;
  import branch_tracker_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_vld = 1'b0;
  logic [15:0] alloc_pc_alt = '0;
  logic [1:0]  alloc_tag;
  logic        alloc_ack;
  logic        resolve_vld = 1'b0;
  logic [1:0]  resolve_tag = '0;
  logic        resolve_mispred = 1'b0;
  logic        brch_full;
  logic        has_mispredict;
  logic [15:0] pc_recovery;
  logic [3:0]  flush_mask;
  logic [2:0]  brch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_tracker dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_vld       (alloc_vld),
    .alloc_pc_alt    (alloc_pc_alt),
    .alloc_tag       (alloc_tag),
    .alloc_ack       (alloc_ack),
    .resolve_vld     (resolve_vld),
    .resolve_tag     (resolve_tag),
    .resolve_mispred (resolve_mispred),
    .brch_full       (brch_full),
    .has_mispredict  (has_mispredict),
    .pc_recovery     (pc_recovery),
    .flush_mask      (flush_mask),
    .brch_cnt        (brch_cnt)
  );

  // ---------------- reference model: program-ordered list of in-flight branches
  typedef struct {
    int          tag;
    logic [15:0] pc;
    bit          res;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_tail;
  bit          m_rec;
  logic [15:0] m_pc;
  logic [3:0]  m_mask;

  function automatic int m_find(input int tag);
    foreach (mq[j]) if (mq[j].tag == tag) return j;
    return -1;
  endfunction

  function automatic bit m_ack(input bit avld, input bit rvld, input int rtag, input bit rmis);
    bit mis;
    mis = rvld && rmis && (m_find(rtag) >= 0);
    return avld && (mq.size() < 4) && !m_rec && !mis;
  endfunction

  task automatic m_clear();
    mq.delete();
    m_tail = 0;
    m_rec  = 1'b0;
    m_pc   = '0;
    m_mask = '0;
  endtask

  task automatic m_step(input bit avld, input logic [15:0] apc, input bit rvld,
                        input int rtag, input bit rmis);
    int     k;
    bit     mis, fr, ack;
    m_ent_t e;
    k   = rvld ? m_find(rtag) : -1;
    mis = (k >= 0) && rmis;
    fr  = (mq.size() > 0) && mq[0].res && !(mis && k == 0);
    ack = m_ack(avld, rvld, rtag, rmis);
    if (mis) begin
      m_rec  = 1'b1;
      m_pc   = mq[k].pc;
      m_mask = '0;
      for (int j = k; j < mq.size(); j++) m_mask[mq[j].tag] = 1'b1;
      while (mq.size() > k) void'(mq.pop_back());
      m_tail = rtag;
    end else begin
      m_rec  = 1'b0;
      m_pc   = '0;
      m_mask = '0;
      if (k >= 0) begin
        e = mq[k];
        e.res = 1'b1;
        mq[k] = e;
      end
      if (ack) begin
        e.tag = m_tail;
        e.pc  = apc;
        e.res = 1'b0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % 4;
      end
    end
    if (fr) void'(mq.pop_front());
  endtask

  // One clock of stimulus, entered and left on a falling edge.
  task automatic drive_cycle(input bit avld, input logic [15:0] apc, input bit rvld,
                             input int rtag, input bit rmis,
                             output logic ack_seen, output logic [1:0] tag_seen);
    alloc_vld       = avld;
    alloc_pc_alt    = apc;
    resolve_vld     = rvld;
    resolve_tag     = rtag[1:0];
    resolve_mispred = rmis;
    #1;
    ack_seen = alloc_ack;
    tag_seen = alloc_tag;
    @(posedge clk);
    m_step(avld, apc, rvld, rtag, rmis);
    @(negedge clk);
    alloc_vld       = 1'b0;
    resolve_vld     = 1'b0;
    resolve_mispred = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_vld = 1'b0;
    resolve_vld = 1'b0;
    resolve_mispred = 1'b0;
    m_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    m_clear();
    @(negedge clk);
    n_checks++; if (brch_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", brch_cnt); end
    n_checks++; if (brch_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", brch_full); end
    n_checks++; if (has_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", has_mispredict); end
    n_checks++; if (flush_mask !== 4'h0 || pc_recovery !== 16'h0) begin n_fail++; $display("FAIL reset_rec: mask %h pc %h want 0", flush_mask, pc_recovery); end
    n_checks++; if (alloc_tag !== 2'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", alloc_tag); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill4(input logic [15:0] base);
    logic a; logic [1:0] t;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, base + 16'(i), 1'b0, 0, 1'b0, a, t);
      n_checks++; if (a !== 1'b1 || t !== 2'(i)) begin n_fail++; $display("FAIL fill_alloc%0d: ack %b tag %0d want 1 %0d", i, a, t, i); end
    end
  endtask

  task automatic test_fill();
    logic a; logic [1:0] t;
    do_reset();
    fill4(16'h0100);
    n_checks++; if (brch_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", brch_full); end
    n_checks++; if (brch_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_cnt: got %0d want 4", brch_cnt); end
    drive_cycle(1'b1, 16'h0104, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL fill_fifth_ack: got %b want 0", a); end
    n_checks++; if (brch_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_cnt_after: got %0d want 4", brch_cnt); end
  endtask

  task automatic test_inorder_free();
    logic a; logic [1:0] t;
    do_reset();
    fill4(16'h0100);
    drive_cycle(1'b0, 16'h0, 1'b1, 2, 1'b0, a, t);
    drive_cycle(1'b0, 16'h0, 1'b1, 0, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd4) begin n_fail++; $display("FAIL free_cnt_a: got %0d want 4", brch_cnt); end
    drive_cycle(1'b0, 16'h0, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd3) begin n_fail++; $display("FAIL free_cnt_b: got %0d want 3", brch_cnt); end
    drive_cycle(1'b0, 16'h0, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd3) begin n_fail++; $display("FAIL free_hold2: got %0d want 3", brch_cnt); end
    drive_cycle(1'b0, 16'h0, 1'b1, 1, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd3) begin n_fail++; $display("FAIL free_cnt_c: got %0d want 3", brch_cnt); end
    drive_cycle(1'b0, 16'h0, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd2) begin n_fail++; $display("FAIL free_cnt_d: got %0d want 2", brch_cnt); end
    drive_cycle(1'b0, 16'h0, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd1) begin n_fail++; $display("FAIL free_cnt_e: got %0d want 1", brch_cnt); end
  endtask

  task automatic test_mispredict();
    logic a; logic [1:0] t;
    do_reset();
    fill4(16'h0100);
    drive_cycle(1'b0, 16'h0, 1'b1, 1, 1'b1, a, t);
    n_checks++; if (has_mispredict !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b want 1", has_mispredict); end
    n_checks++; if (pc_recovery !== 16'h0101) begin n_fail++; $display("FAIL mis_pc: got %h want 0101", pc_recovery); end
    n_checks++; if (flush_mask !== 4'b1110) begin n_fail++; $display("FAIL mis_mask: got %b want 1110", flush_mask); end
    n_checks++; if (brch_cnt !== 3'd1) begin n_fail++; $display("FAIL mis_cnt: got %0d want 1", brch_cnt); end
    n_checks++; if (alloc_tag !== 2'd1) begin n_fail++; $display("FAIL mis_tag: got %0d want 1", alloc_tag); end
    drive_cycle(1'b1, 16'h0E00, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL mis_recover_ack: got %b want 0", a); end
    n_checks++; if (has_mispredict !== 1'b0 || flush_mask !== 4'h0 || pc_recovery !== 16'h0) begin
      n_fail++; $display("FAIL mis_pulse_end: mis %b mask %b pc %h want 0", has_mispredict, flush_mask, pc_recovery); end
    drive_cycle(1'b1, 16'h0E01, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (a !== 1'b1 || t !== 2'd1) begin n_fail++; $display("FAIL mis_realloc: ack %b tag %0d want 1 1", a, t); end
  endtask

  task automatic test_wrap();
    logic a; logic [1:0] t;
    do_reset();
    drive_cycle(1'b1, 16'h0A10, 1'b0, 0, 1'b0, a, t);
    drive_cycle(1'b1, 16'h0A11, 1'b1, 0, 1'b0, a, t);
    drive_cycle(1'b1, 16'h0A12, 1'b1, 1, 1'b0, a, t);
    drive_cycle(1'b0, 16'h0,    1'b1, 2, 1'b0, a, t);
    for (int c = 0; c < 8 && brch_cnt !== 3'd0; c++) drive_cycle(1'b0, 16'h0, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd0 || alloc_tag !== 2'd3) begin n_fail++; $display("FAIL wrap_drain: cnt %0d tag %0d want 0 3", brch_cnt, alloc_tag); end
    drive_cycle(1'b1, 16'h0A03, 1'b0, 0, 1'b0, a, t);
    drive_cycle(1'b1, 16'h0A00, 1'b0, 0, 1'b0, a, t);
    drive_cycle(1'b1, 16'h0A01, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (t !== 2'd1 || brch_cnt !== 3'd3) begin n_fail++; $display("FAIL wrap_alloc: tag %0d cnt %0d want 1 3", t, brch_cnt); end
    drive_cycle(1'b1, 16'h0BAD, 1'b1, 0, 1'b1, a, t);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wrap_coincident_ack: got %b want 0", a); end
    n_checks++; if (flush_mask !== 4'b0011) begin n_fail++; $display("FAIL wrap_mask: got %b want 0011", flush_mask); end
    n_checks++; if (brch_cnt !== 3'd1 || alloc_tag !== 2'd0) begin n_fail++; $display("FAIL wrap_cnt_tail: cnt %0d tail %0d want 1 0", brch_cnt, alloc_tag); end
    n_checks++; if (pc_recovery !== 16'h0A00) begin n_fail++; $display("FAIL wrap_pc: got %h want 0a00", pc_recovery); end
  endtask

  task automatic test_head_mispred_reset();
    logic a; logic [1:0] t;
    do_reset();
    drive_cycle(1'b1, 16'h0C00, 1'b0, 0, 1'b0, a, t);
    drive_cycle(1'b1, 16'h0C01, 1'b1, 0, 1'b0, a, t);
    drive_cycle(1'b1, 16'h0C02, 1'b0, 0, 1'b0, a, t);
    drive_cycle(1'b0, 16'h0,    1'b1, 2, 1'b0, a, t);
    n_checks++; if (brch_cnt !== 3'd2) begin n_fail++; $display("FAIL head_pre_cnt: got %0d want 2", brch_cnt); end
    drive_cycle(1'b0, 16'h0, 1'b1, 1, 1'b1, a, t);
    n_checks++; if (brch_cnt !== 3'd0 || alloc_tag !== 2'd1) begin n_fail++; $display("FAIL head_mis: cnt %0d tail %0d want 0 1", brch_cnt, alloc_tag); end
    n_checks++; if (flush_mask !== 4'b0110 || pc_recovery !== 16'h0C01) begin n_fail++; $display("FAIL head_mis_rec: mask %b pc %h want 0110 0c01", flush_mask, pc_recovery); end
    // Abort recovery with reset while the pulse is high.
    rst_n = 1'b0;
    m_clear();
    #1;
    n_checks++; if ({has_mispredict, brch_full, alloc_ack} !== 3'b000 || flush_mask !== 4'h0 || pc_recovery !== 16'h0
                    || brch_cnt !== 3'd0 || alloc_tag !== 2'd0) begin
      n_fail++; $display("FAIL midrec_reset: mis %b full %b ack %b mask %b pc %h cnt %0d tag %0d want all 0",
                         has_mispredict, brch_full, alloc_ack, flush_mask, pc_recovery, brch_cnt, alloc_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b1, 16'h0D00, 1'b0, 0, 1'b0, a, t);
    n_checks++; if (a !== 1'b1 || t !== 2'd0) begin n_fail++; $display("FAIL midrec_first_alloc: ack %b tag %0d want 1 0", a, t); end
    n_checks++; if (brch_cnt !== 3'd1 || has_mispredict !== 1'b0) begin n_fail++; $display("FAIL midrec_after: cnt %0d mis %b want 1 0", brch_cnt, has_mispredict); end
  endtask

  task automatic test_random();
    logic a; logic [1:0] t;
    bit avld, rvld, rmis, exp_ack;
    int rtag;
    logic [15:0] apc;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      avld = ($urandom_range(0, 3) != 0);
      apc  = 16'($urandom);
      rvld = ($urandom_range(0, 1) == 1);
      rmis = ($urandom_range(0, 7) == 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) rtag = mq[$urandom_range(0, mq.size() - 1)].tag;
      else rtag = $urandom_range(0, 3);
      exp_ack = m_ack(avld, rvld, rtag, rmis);
      drive_cycle(avld, apc, rvld, rtag, rmis, a, t);
      n_checks++; if (a !== exp_ack) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b want %b", cyc, a, exp_ack); end
      n_checks++; if (brch_cnt !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", cyc, brch_cnt, mq.size()); end
      n_checks++; if (brch_full !== (mq.size() == 4)) begin n_fail++; $display("FAIL rnd_full@%0d: got %b", cyc, brch_full); end
      n_checks++; if (alloc_tag !== 2'(m_tail)) begin n_fail++; $display("FAIL rnd_tag@%0d: got %0d want %0d", cyc, alloc_tag, m_tail); end
      n_checks++; if (has_mispredict !== m_rec) begin n_fail++; $display("FAIL rnd_mis@%0d: got %b want %b", cyc, has_mispredict, m_rec); end
      n_checks++; if (flush_mask !== m_mask || pc_recovery !== m_pc) begin
        n_fail++; $display("FAIL rnd_rec@%0d: mask %b pc %h want %b %h", cyc, flush_mask, pc_recovery, m_mask, m_pc); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_inorder_free();
    test_mispredict();
    test_wrap();
    test_head_mispred_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_tracker.md
BRANCH_TRACKER -- requirements
Module: branch_tracker

Interface
REQ-001 SHALL have one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-002 SHALL expose:
  clk            in   1   rising-edge clock
  rst_n          in   1   async active-low reset
  alloc_vld      in   1   decode presents a new conditional branch
  alloc_pc_alt   in   16  recovery PC (non-predicted path) for that branch
  alloc_tag      out  2   tag granted to the branch (equals tail pointer)
  alloc_ack      out  1   allocation accepted this cycle
  resolve_vld    in   1   execute resolves one branch
  resolve_tag    in   2   tag being resolved
  resolve_mispred in  1   resolved branch was mispredicted
  brch_full      out  1   all 4 entries occupied; to next-PC selection
  has_mispredict out  1   one-cycle recovery pulse; to next-PC selection
  pc_recovery    out  16  recovery PC, valid while has_mispredict=1
  flush_mask     out  4   tags squashed, valid while has_mispredict=1
  brch_cnt       out  3   occupied entries, 0..4

Function
REQ-003 SHALL hold a 4-entry circular buffer; per entry: valid, resolved, alt_pc[15:0]; pointers head, tail (2 bits, wrap 3->0); count (3 bits).
REQ-004 SHALL drive brch_full = (count==4) and brch_cnt = count, both combinational from registers.
REQ-005 SHALL drive alloc_tag = tail combinationally; alloc_ack = alloc_vld & ~brch_full & (state==NORMAL) & ~mispredict_this_cycle.
REQ-006 On alloc_ack SHALL write entry[tail] {valid=1, resolved=0, alt_pc}, tail+=1, count+=1 at next edge.
REQ-007 alloc_vld while full, while in RECOVER, or coincident with a mispredict resolve SHALL be dropped with no state change.
REQ-008 resolve_vld with resolve_mispred=0 on a valid entry SHALL set its resolved bit; resolve on an invalid tag SHALL be ignored.
REQ-009 Each cycle, if entry[head] is valid and resolved, SHALL free it (valid=0, head+=1, count-=1); at most one free per cycle.
REQ-010 Mispredict resolve on valid tag T SHALL, at next edge: register pc_recovery=alt_pc[T]; set flush_mask bits for T through tail-1 (wrapping); clear those entries; set tail=T; set count=(T-head) mod 4, less 1 if head is freed the same cycle; assert has_mispredict for exactly one cycle.
REQ-011 Mispredict on T==head SHALL leave count=0, head=tail=T.
REQ-012 Allocation in the mispredict cycle SHALL lose to the mispredict (REQ-007); a same-cycle head free of an older entry SHALL still occur.
REQ-013 SHALL implement FSM NORMAL, RECOVER: NORMAL->RECOVER on mispredict resolve; RECOVER->NORMAL after exactly one cycle (the has_mispredict cycle), so wrong-path branches in decode are never allocated.
REQ-014 Resolve arriving during RECOVER for a tag not flushed SHALL be processed normally; for a flushed tag SHALL be ignored.
REQ-015 flush_mask and pc_recovery SHALL read 0 when has_mispredict=0.

Reset
REQ-016 On rst_n=0 SHALL asynchronously clear all valid/resolved bits, head=tail=0, count=0, state=NORMAL, has_mispredict=0, pc_recovery=0, flush_mask=0.
REQ-017 Reset mid-recovery SHALL abort recovery; first cycle after release SHALL accept allocation.

Structure
REQ-018 Shared package SHALL hold BR_DEPTH=4, BR_TAG_W=2, PC_W=16, and the NORMAL/RECOVER state encoding.
REQ-019 Entry storage SHALL be one sub-module, branch_entry_file (4x{valid,resolved,alt_pc}, one write port, one mispredict-read port, mask-clear input); pointer/count/FSM logic in branch_tracker.

Verification
REQ-020 Reset, then 4 allocs (alt_pc 0x0100..0x0103) -> alloc_tag 0,1,2,3; brch_full=1, brch_cnt=4; 5th alloc gives alloc_ack=0.
REQ-021 Tags 0..3 allocated, resolve tag 2 correct then tag 0 correct -> tag 0 frees next cycle, tag 2 held until tag 1 resolved; brch_cnt 4->3, then 3->1 over two cycles after tag 1 resolves.
REQ-022 Tags 0..3 allocated, mispredict tag 1 -> next cycle has_mispredict=1, pc_recovery=0x0101, flush_mask=4'b1110, brch_cnt=1, next alloc_tag=1.
REQ-023 Wrap: head=3, tags 3,0,1 live, mispredict tag 0 with simultaneous alloc_vld -> alloc_ack=0, flush_mask=4'b0011, brch_cnt=1, tail=0.
REQ-024 Mispredict on head with head already resolved-pending elsewhere -> brch_cnt=0, head=tail; rst_n pulsed during has_mispredict -> all outputs 0, alloc accepted first cycle after release.
